// File: rtl/i2s_dac_tx.sv
// ---------------------------------------------------------------------------
// i2s_dac_tx
// I2S transmitter for the codec DAC path. Runs on the audio master clock.
// It divides that clock into BCLK/LRCK and serialises one stereo sample pair
// per frame, MSB first, one BCLK after each LRCK edge. A 1-deep valid/ready
// holding buffer feeds the per-frame shadow registers. The whole block idles
// with quiet outputs while the audio PLL is out of lock.
//
// Ports
//   clk          audio master clock
//   rst_n        synchronous active-low reset
//   pll_locked   PLL lock, asynchronous to clk (2-flop synchronised here)
//   l_data       left sample, two's complement
//   r_data       right sample, two's complement
//   in_valid     l_data/r_data valid
//   in_ready     holding buffer empty (transfer on in_valid & in_ready)
//   aud_bclk     bit clock to codec
//   aud_daclrck  word select, 0 = left slot, 1 = right slot
//   aud_dacdat   serial data, changes on BCLK falling edge
//   frame_start  1-cycle pulse when a frame is loaded
//   underrun     1-cycle pulse when a frame loads from an empty buffer
// ---------------------------------------------------------------------------
module i2s_dac_tx #(
    parameter int SAMPLE_W  = 24,
    parameter int SLOT_BITS = 32,
    parameter int MCLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pll_locked,
    input  logic [SAMPLE_W-1:0] l_data,
    input  logic [SAMPLE_W-1:0] r_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                aud_bclk,
    output logic                aud_daclrck,
    output logic                aud_dacdat,
    output logic                frame_start,
    output logic                underrun
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (MCLK_DIV > 2) ? $clog2(MCLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int IDX_W      = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(MCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(MCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_LIM  = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] SAMP_LIM  = BIT_W'(SAMPLE_W);
    localparam logic [DIV_W-1:0] DIV_ZERO  = {DIV_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ZERO  = {BIT_W{1'b0}};
    localparam logic [SAMPLE_W-1:0] SAMP_ZERO = {SAMPLE_W{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_r;
    logic                sync1_r;
    logic                sync2_r;
    logic [DIV_W-1:0]    div_cnt_r;
    logic [BIT_W-1:0]    bit_cnt_r;
    logic [SAMPLE_W-1:0] buf_left_r;
    logic [SAMPLE_W-1:0] buf_right_r;
    logic                buf_full_r;
    logic [SAMPLE_W-1:0] shadow_left_r;
    logic [SAMPLE_W-1:0] shadow_right_r;
    logic                in_ready_r;
    logic                bclk_r;
    logic                lrck_r;
    logic                dat_r;
    logic                frame_start_r;
    logic                underrun_r;

    logic                lock_s;
    logic                enter_s;
    logic                leave_s;
    logic                fe_s;
    logic                run_nxt_s;
    logic [DIV_W-1:0]    div_nxt_s;
    logic [BIT_W-1:0]    bit_nxt_s;
    logic                slot_right_s;
    logic [BIT_W-1:0]    pos_s;
    logic [SAMPLE_W-1:0] word_s;
    logic [IDX_W-1:0]    idx_s;
    logic                ser_bit_s;
    logic                load_s;
    logic                accept_s;
    logic                buf_full_nxt_s;

    assign lock_s = sync2_r;

    // Decide entry/exit of RUN and whether this clock edge is a BCLK falling event
    always_comb begin
        enter_s = 1'b0;
        leave_s = 1'b0;
        fe_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (lock_s) begin
                    // Entering RUN is itself the first falling event
                    enter_s = 1'b1;
                    fe_s    = 1'b1;
                end else begin
                    enter_s = 1'b0;
                    fe_s    = 1'b0;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    leave_s = 1'b1;
                end else if (div_cnt_r == DIV_LAST) begin
                    fe_s = 1'b1;
                end else begin
                    fe_s = 1'b0;
                end
            end
            default: begin
                leave_s = 1'b1;
            end
        endcase
        run_nxt_s = enter_s | ((state_r == ST_RUN) & ~leave_s);
    end

    // Next values of the clock divider and the frame bit counter
    always_comb begin
        div_nxt_s = DIV_ZERO;
        if ((state_r == ST_RUN) && !leave_s) begin
            if (div_cnt_r == DIV_LAST) begin
                div_nxt_s = DIV_ZERO;
            end else begin
                div_nxt_s = div_cnt_r + DIV_W'(1);
            end
        end else begin
            div_nxt_s = DIV_ZERO;
        end

        bit_nxt_s = bit_cnt_r;
        if (enter_s) begin
            bit_nxt_s = BIT_ZERO;
        end else if (bit_cnt_r == BIT_LAST) begin
            bit_nxt_s = BIT_ZERO;
        end else begin
            bit_nxt_s = bit_cnt_r + BIT_W'(1);
        end
    end

    // Pick the serial bit for the slot position about to be driven
    always_comb begin
        slot_right_s = (bit_nxt_s >= SLOT_LIM);
        pos_s        = bit_nxt_s;
        word_s       = shadow_left_r;
        if (slot_right_s) begin
            pos_s  = bit_nxt_s - SLOT_LIM;
            word_s = shadow_right_r;
        end else begin
            pos_s  = bit_nxt_s;
            word_s = shadow_left_r;
        end
        idx_s = IDX_W'(SAMP_LIM - pos_s);
        // Position 0 is the I2S one-BCLK delay; positions past the sample pad with 0
        if ((pos_s != BIT_ZERO) && (pos_s <= SAMP_LIM)) begin
            ser_bit_s = word_s[idx_s];
        end else begin
            ser_bit_s = 1'b0;
        end
    end

    // Holding buffer occupancy; an accept on a load edge with an empty buffer keeps the new pair
    always_comb begin
        load_s         = fe_s & (bit_nxt_s == BIT_ZERO);
        accept_s       = in_valid & in_ready_r;
        buf_full_nxt_s = buf_full_r;
        if (leave_s) begin
            buf_full_nxt_s = 1'b0;
        end else if (accept_s) begin
            buf_full_nxt_s = 1'b1;
        end else if (load_s) begin
            buf_full_nxt_s = 1'b0;
        end else begin
            buf_full_nxt_s = buf_full_r;
        end
    end

    // State machine, counters, buffer, shadows and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            sync1_r        <= 1'b0;
            sync2_r        <= 1'b0;
            div_cnt_r      <= DIV_ZERO;
            bit_cnt_r      <= BIT_ZERO;
            buf_left_r     <= SAMP_ZERO;
            buf_right_r    <= SAMP_ZERO;
            buf_full_r     <= 1'b0;
            shadow_left_r  <= SAMP_ZERO;
            shadow_right_r <= SAMP_ZERO;
            in_ready_r     <= 1'b0;
            bclk_r         <= 1'b0;
            lrck_r         <= 1'b0;
            dat_r          <= 1'b0;
            frame_start_r  <= 1'b0;
            underrun_r     <= 1'b0;
        end else begin
            sync1_r    <= pll_locked;
            sync2_r    <= sync1_r;
            state_r    <= run_nxt_s ? ST_RUN : ST_IDLE;
            div_cnt_r  <= div_nxt_s;
            // BCLK is registered from the next divider value so it matches div_cnt_r
            bclk_r     <= run_nxt_s & (div_nxt_s >= DIV_HALF);
            in_ready_r <= run_nxt_s & ~buf_full_nxt_s;
            buf_full_r <= buf_full_nxt_s;

            if (accept_s && !leave_s) begin
                buf_left_r  <= l_data;
                buf_right_r <= r_data;
            end

            if (!run_nxt_s) begin
                bit_cnt_r     <= BIT_ZERO;
                lrck_r        <= 1'b0;
                dat_r         <= 1'b0;
                frame_start_r <= 1'b0;
                underrun_r    <= 1'b0;
            end else if (fe_s) begin
                bit_cnt_r     <= bit_nxt_s;
                lrck_r        <= slot_right_s;
                dat_r         <= ser_bit_s;
                frame_start_r <= load_s;
                underrun_r    <= load_s & ~buf_full_r;
                if (load_s) begin
                    if (buf_full_r) begin
                        shadow_left_r  <= buf_left_r;
                        shadow_right_r <= buf_right_r;
                    end else begin
                        shadow_left_r  <= SAMP_ZERO;
                        shadow_right_r <= SAMP_ZERO;
                    end
                end
            end else begin
                frame_start_r <= 1'b0;
                underrun_r    <= 1'b0;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign aud_bclk    = bclk_r;
    assign aud_daclrck = lrck_r;
    assign aud_dacdat  = dat_r;
    assign frame_start = frame_start_r;
    assign underrun    = underrun_r;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_dac_tx
// Directed bench for i2s_dac_tx with default parameters (24-bit samples,
// 32-bit slots, MCLK/4 bit clock). A table of sample pairs with hand-computed
// slot words drives the data path; hand-written sequences cover reset,
// clock/LRCK timing, underrun, backpressure and lock loss. Each captured slot
// word holds slot position 0 in bit 31 down to position 31 in bit 0, so a
// sample d appears as {1'b0, d, 7'b0}.
// ---------------------------------------------------------------------------
module tb_i2s_dac_tx;

    logic        clk;
    logic        rst_n;
    logic        pll_locked;
    logic [23:0] l_data;
    logic [23:0] r_data;
    logic        in_valid;
    logic        in_ready;
    logic        aud_bclk;
    logic        aud_daclrck;
    logic        aud_dacdat;
    logic        frame_start;
    logic        underrun;

    int tests;
    int fails;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
    } vec_t;

    vec_t vecs [0:4];

    i2s_dac_tx #(
        .SAMPLE_W  (24),
        .SLOT_BITS (32),
        .MCLK_DIV  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .l_data      (l_data),
        .r_data      (r_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .aud_dacdat  (aud_dacdat),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    // 100 MHz simulation clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a stuck run
    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to the negedge where the next frame_start pulse is visible
    task automatic wait_frame_start(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Wait for in_ready, present one pair for one cycle
    task automatic send_pair(input logic [23:0] l, input logic [23:0] r, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            l_data   = l;
            r_data   = r;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Sample data and LRCK on 64 BCLK rising edges, starting right after a load
    task automatic capture_frame(output logic [31:0] lw, output logic [31:0] rw,
                                 output int lr_err, output int rises);
        logic prev;
        lw     = 32'h0;
        rw     = 32'h0;
        lr_err = 0;
        rises  = 0;
        prev   = aud_bclk;
        for (int c = 0; c < 300; c++) begin
            if (rises >= 64) break;
            @(negedge clk);
            if ((aud_bclk === 1'b1) && (prev === 1'b0)) begin
                if (rises < 32) begin
                    lw = {lw[30:0], aud_dacdat};
                    if (aud_daclrck !== 1'b0) lr_err++;
                end else begin
                    rw = {rw[30:0], aud_dacdat};
                    if (aud_daclrck !== 1'b1) lr_err++;
                end
                rises++;
            end
            prev = aud_bclk;
        end
    endtask

    // Main sequence
    initial begin
        bit          ok;
        logic [31:0] lw;
        logic [31:0] rw;
        int          lr_err;
        int          rises;
        int          bclk_err;
        int          lrck_err;
        int          dat_ones;
        int          fs_cnt;
        int          ur_cnt;
        int          pos_err;
        int          wait_cnt;
        int          idle_err;
        logic        exp_b;

        tests = 0;
        fails = 0;

        vecs[0] = '{l: 24'h800001, r: 24'h7FFFFE, exp_l: 32'h40000080, exp_r: 32'h3FFFFF00};
        vecs[1] = '{l: 24'hA5A5A5, r: 24'h123456, exp_l: 32'h52D2D280, exp_r: 32'h091A2B00};
        vecs[2] = '{l: 24'hFFFFFF, r: 24'h000000, exp_l: 32'h7FFFFF80, exp_r: 32'h00000000};
        vecs[3] = '{l: 24'h000001, r: 24'h800000, exp_l: 32'h00000080, exp_r: 32'h40000000};
        vecs[4] = '{l: 24'h000000, r: 24'hFFFFFF, exp_l: 32'h00000000, exp_r: 32'h7FFFFF80};

        rst_n      = 1'b0;
        pll_locked = 1'b1;
        in_valid   = 1'b0;
        l_data     = 24'h0;
        r_data     = 24'h0;

        // Reset held 4 cycles with lock asserted: every output low
        repeat (4) @(negedge clk);
        check("reset_outputs",
              {in_ready, aud_bclk, aud_daclrck, aud_dacdat, frame_start, underrun}, 6'b000000);

        // RUN starts on the third edge after release, loading zeros
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("startup_cycle%0d", k), {frame_start, underrun, in_ready},
                  (k == 3) ? 3'b111 : 3'b000);
        end

        // Three idle frames: clock shapes, silent data, one underrun per frame
        bclk_err = 0; lrck_err = 0; dat_ones = 0; fs_cnt = 0; ur_cnt = 0; pos_err = 0;
        for (int i = 0; i < 768; i++) begin
            exp_b = ((i % 4) >= 2) ? 1'b1 : 1'b0;
            if (aud_bclk !== exp_b) bclk_err++;
            exp_b = (((i / 4) % 64) >= 32) ? 1'b1 : 1'b0;
            if (aud_daclrck !== exp_b) lrck_err++;
            if (aud_dacdat !== 1'b0) dat_ones++;
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if ((i % 256) != 0) pos_err++;
            end
            if (underrun === 1'b1) begin
                ur_cnt++;
                if ((i % 256) != 0) pos_err++;
            end
            if (i < 767) @(negedge clk);
        end
        check("bclk_waveform_errors", bclk_err, 0);
        check("lrck_waveform_errors", lrck_err, 0);
        check("underrun_data_ones", dat_ones, 0);
        check("underrun_frame_start_count", fs_cnt, 3);
        check("underrun_pulse_count", ur_cnt, 3);
        check("pulse_position_errors", pos_err, 0);

        // Table-driven data vectors, one pair per frame
        wait_frame_start(ok);
        check("align_frame_seen", ok, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send_pair(vecs[i].l, vecs[i].r, ok);
            check($sformatf("vec%0d_accept", i), ok, 1'b1);
            wait_frame_start(ok);
            check($sformatf("vec%0d_frame_seen", i), ok, 1'b1);
            check($sformatf("vec%0d_underrun", i), underrun, 1'b0);
            capture_frame(lw, rw, lr_err, rises);
            check($sformatf("vec%0d_rises", i), rises, 64);
            check($sformatf("vec%0d_left", i), lw, vecs[i].exp_l);
            check($sformatf("vec%0d_right", i), rw, vecs[i].exp_r);
            check($sformatf("vec%0d_lrck", i), lr_err, 0);
        end

        // Backpressure: two pairs back to back
        wait_frame_start(ok);
        check("bp_frame_seen", ok, 1'b1);
        check("bp_empty_frame_underrun", underrun, 1'b1);
        l_data   = 24'h5A5A5A;
        r_data   = 24'h0F0F0F;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_ready_low_after_accept", in_ready, 1'b0);
        l_data   = 24'hC3C3C3;
        r_data   = 24'h3C3C3C;
        wait_cnt = 0;
        while ((in_ready !== 1'b1) && (wait_cnt < 600)) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("bp_ready_low_cycles", wait_cnt, 255);
        check("bp_ready_with_load", frame_start, 1'b1);
        check("bp_first_no_underrun", underrun, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_ready_low_after_second", in_ready, 1'b0);
        capture_frame(lw, rw, lr_err, rises);
        check("bp_first_left", lw, 32'h2D2D2D00);
        check("bp_first_right", rw, 32'h07878780);
        wait_frame_start(ok);
        check("bp_second_frame_seen", ok, 1'b1);
        check("bp_second_no_underrun", underrun, 1'b0);
        capture_frame(lw, rw, lr_err, rises);
        check("bp_second_left", lw, 32'h61E1E180);
        check("bp_second_right", rw, 32'h1E1E1E00);
        check("bp_second_lrck", lr_err, 0);
        wait_frame_start(ok);
        check("bp_no_duplicate", {ok, underrun}, 2'b11);

        // Lock loss mid-left-slot, then relock
        send_pair(24'h111111, 24'h222222, ok);
        check("lock_pair_accept", ok, 1'b1);
        repeat (59) @(negedge clk);
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        check("lock_still_running", aud_bclk, 1'b1);
        @(negedge clk);
        check("lock_lost_outputs",
              {in_ready, aud_bclk, aud_daclrck, aud_dacdat, frame_start, underrun}, 6'b000000);
        l_data   = 24'h333333;
        r_data   = 24'h444444;
        in_valid = 1'b1;
        idle_err = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ({in_ready, aud_bclk, aud_daclrck, aud_dacdat, frame_start, underrun} !== 6'b000000)
                idle_err++;
        end
        check("idle_quiet", idle_err, 0);
        in_valid   = 1'b0;
        pll_locked = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("relock_cycle%0d", k), {frame_start, underrun, in_ready},
                  (k == 3) ? 3'b111 : 3'b000);
        end
        capture_frame(lw, rw, lr_err, rises);
        check("relock_rises", rises, 64);
        check("relock_left_zero", lw, 32'h0);
        check("relock_right_zero", rw, 32'h0);
        check("relock_lrck", lr_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
